bit_serial_alu_ctrl: RTL and testbench

//  Sequencer that runs WIDTH-bit ALU operations through one single-bit ALU slice, one bit per clock, LSB first.

---
 rtl/bit_serial_alu_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// bit_serial_alu_ctrl
//
// Runs WIDTH-bit ALU operations through a single-bit ALU slice, one bit per
// clock, LSB first. Operand and result shift registers plus a registered carry
// carry the state between bits. The command encoding is the same as the
// single-bit ALU's:
//   000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR
//
// Optional feature macro: BSALU_FLAGS_EN
//   defined   : zero/overflow are computed and registered at RUN->DONE
//   undefined : zero/overflow are tied to 0 and the flag logic is removed
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   in_valid   in   1      operation request valid
//   in_ready   out  1      request can be accepted (IDLE only)
//   operandA   in   WIDTH  operand A, sampled on accept
//   operandB   in   WIDTH  operand B, sampled on accept
//   command    in   3      ALU command
//   out_valid  out  1      result valid (DONE only)
//   out_ready  in   1      consumer takes the result
//   result     out  WIDTH  operation result, stable while out_valid
//   carryout   out  1      final carry of ADD/SUB/SLT, 0 for logic ops
//   overflow   out  1      signed overflow of ADD/SUB
//   zero       out  1      result == 0
// -----------------------------------------------------------------------------
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [2:0]       command,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] CMD_ADD  = 3'b000;
  localparam logic [2:0] CMD_SUB  = 3'b001;
  localparam logic [2:0] CMD_XOR  = 3'b010;
  localparam logic [2:0] CMD_SLT  = 3'b011;
  localparam logic [2:0] CMD_AND  = 3'b100;
  localparam logic [2:0] CMD_NAND = 3'b101;
  localparam logic [2:0] CMD_NOR  = 3'b110;
  localparam logic [2:0] CMD_OR   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // SUB and SLT are computed as A + ~B + 1.
  function automatic logic f_is_sub(input logic [2:0] cmd);
    return (cmd == CMD_SUB) || (cmd == CMD_SLT);
  endfunction

  function automatic logic f_is_arith(input logic [2:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SLT);
  endfunction

  // One-bit ALU slice: returns {carry_out, bit_out}.
  function automatic logic [1:0] f_slice(input logic [2:0] cmd, input logic a,
                                         input logic b, input logic cin);
    logic [1:0] v_out;
    v_out = 2'b00;
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_SLT: v_out = {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
      CMD_XOR:  v_out = {1'b0, a ^ b};
      CMD_AND:  v_out = {1'b0, a & b};
      CMD_NAND: v_out = {1'b0, ~(a & b)};
      CMD_NOR:  v_out = {1'b0, ~(a | b)};
      CMD_OR:   v_out = {1'b0, a | b};
      default:  v_out = 2'b00;
    endcase
    return v_out;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_cmd;
  // Holds the WIDTH-1 bits produced so far; the last bit goes straight
  // into result on the final edge.
  logic [WIDTH-2:0] r_sh;

  logic [1:0]       w_slice;
  logic             w_bit;
  logic             w_cout;
  logic             w_ovf;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_final;

  assign w_slice  = f_slice(r_cmd, r_a[0], r_b[0], r_carry);
  assign w_bit    = w_slice[0];
  assign w_cout   = w_slice[1];
  // On the final bit r_carry is the carry into the MSB.
  assign w_ovf    = r_carry ^ w_cout;
  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_BIT);
  assign w_shift  = {w_bit, r_sh};
  // SLT: signed less-than is sign(A-B) corrected by the subtract overflow.
  assign w_final  = (r_cmd == CMD_SLT) ? {{(WIDTH-1){1'b0}}, w_bit ^ w_ovf} : w_shift;

  // Datapath shift registers: only meaningful between accept and DONE,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a   <= operandA;
      r_b   <= f_is_sub(command) ? ~operandB : operandB;
      r_cmd <= command;
    end else if (r_state == S_RUN) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_sh  <= w_shift[WIDTH-1:1];
    end
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carryout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state  <= S_RUN;
            in_ready <= 1'b0;
            r_cnt    <= '0;
            r_carry  <= f_is_sub(command);
          end
        end
        S_RUN: begin
          if (f_is_arith(r_cmd)) begin
            r_carry <= w_cout;
          end
          if (r_cnt == LAST_BIT) begin
            r_state   <= S_DONE;
            r_cnt     <= '0;
            out_valid <= 1'b1;
            result    <= w_final;
            carryout  <= f_is_arith(r_cmd) & w_cout;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BSALU_FLAGS_EN
  // Flags update only on the final RUN edge so they never move mid-operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (w_last) begin
      overflow <= ((r_cmd == CMD_ADD) || (r_cmd == CMD_SUB)) & w_ovf;
      zero     <= (w_final == '0);
    end
  end
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
module tb_bit_serial_alu_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic [2:0]   cmd;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;
  logic         zero;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [W-1:0] prev_res;

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operandA  (opa),
    .operandB  (opb),
    .command   (cmd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carryout  (carryout),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model in plain integer arithmetic.
  function automatic void ref_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic co, output logic ov,
                                 output logic z);
    logic [W:0] s;
    r  = '0;
    co = 1'b0;
    ov = 1'b0;
    case (c)
      3'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd3: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        co = s[W];
        r  = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      end
      3'd2: r = a ^ b;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    z = (r == '0);
`ifndef BSALU_FLAGS_EN
    ov = 1'b0;
    z  = 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Full transaction: accept, latency, no mid-run result change, outputs, release.
  task automatic do_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold);
    logic [W-1:0] er;
    logic eco, eov, ez;
    int  k;
    bit  seen;
    bit  moved;
    ref_op(c, a, b, er, eco, eov, ez);
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_wait: in_ready=%b required 1", in_ready);
    end
    cmd = c; opa = a; opb = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; opa = $urandom; opb = $urandom; cmd = 3'($urandom);
    k = 0; seen = 0; moved = 0;
    while (!seen && k < 100) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (out_valid) seen = 1;
      else if (result !== prev_res) moved = 1;
    end
    n_vec++;
    if (!seen || k != W) begin
      n_fail++;
      $display("FAIL latency cmd=%0d: %0d edges (seen=%0b) required %0d", c, k, seen, W);
    end
    n_vec++;
    if (moved) begin
      n_fail++;
      $display("FAIL run_stable cmd=%0d: result changed during RUN, required %h", c, prev_res);
    end
    n_vec++;
    if (result !== er) begin
      n_fail++;
      $display("FAIL result cmd=%0d a=%h b=%h: got %h required %h", c, a, b, result, er);
    end
    n_vec++;
    if (carryout !== eco) begin
      n_fail++;
      $display("FAIL carryout cmd=%0d a=%h b=%h: got %b required %b", c, a, b, carryout, eco);
    end
    n_vec++;
    if (overflow !== eov) begin
      n_fail++;
      $display("FAIL overflow cmd=%0d a=%h b=%h: got %b required %b", c, a, b, overflow, eov);
    end
    n_vec++;
    if (zero !== ez) begin
      n_fail++;
      $display("FAIL zero cmd=%0d a=%h b=%h: got %b required %b", c, a, b, zero, ez);
    end
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    prev_res = er;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opa = '0; opb = '0; cmd = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid, carryout, overflow, zero} !== 5'b10000 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b co=%b ov=%b z=%b res=%h required 1/0/0/0/0/0",
               in_ready, out_valid, carryout, overflow, zero, result);
    end
    reset = 1'b0;
    prev_res = '0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1);
    do_op(3'd1, 32'd5, 32'd7, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op(3'd3, 32'h0000_0001, 32'hFFFF_FFFF, 0);
    do_op(3'd3, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    do_op(3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    do_op(3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    do_op(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    do_op(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    do_op(3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
  endtask

  task automatic test_hold();
    logic [W-1:0] er, er2;
    logic eco, eov, ez, eco2, eov2, ez2;
    int  k;
    bit  bad;
    ref_op(3'd0, 32'h1234_5678, 32'h1111_1111, er, eco, eov, ez);
    ref_op(3'd2, 32'hA5A5_0F0F, 32'h0F0F_A5A5, er2, eco2, eov2, ez2);
    cmd = 3'd0; opa = 32'h1234_5678; opb = 32'h1111_1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; opa = $urandom; opb = $urandom; cmd = 3'($urandom);
      @(negedge clk);
      if (result !== er || carryout !== eco || overflow !== eov || zero !== ez ||
          out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1;
    end
    n_vec++;
    if (bad) begin
      n_fail++;
      $display("FAIL done_hold: res=%h vld=%b rdy=%b required %h/1/0", result, out_valid, in_ready, er);
    end
    // Request and release together: only the release takes effect this edge.
    cmd = 3'd2; opa = 32'hA5A5_0F0F; opb = 32'h0F0F_A5A5; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL concurrent_release: rdy=%b vld=%b required 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_after_idle: in_ready=%b required 0", in_ready);
    end
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (result !== er2 || carryout !== eco2) begin
      n_fail++;
      $display("FAIL hold_second_op: res=%h co=%b required %h/%b", result, carryout, er2, eco2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    prev_res = er2;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, er;
    logic [2:0] c;
    logic eco, eov, ez;
    int k, t, tprev;
    tprev = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (!in_ready && k < 200) begin
        @(negedge clk);
        k++;
      end
      t = cyc;
      if (i > 0) begin
        n_vec++;
        if (t - tprev != W + 2) begin
          n_fail++;
          $display("FAIL initiation_interval: %0d cycles required %0d", t - tprev, W + 2);
        end
      end
      tprev = t;
      c = 3'($urandom_range(0, 7)); a = pick_operand(); b = pick_operand();
      ref_op(c, a, b, er, eco, eov, ez);
      cmd = c; opa = a; opb = b;
      @(posedge clk); #1;
      opa = $urandom; opb = $urandom; cmd = 3'($urandom);
      k = 0;
      while (!out_valid && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (i == 3) in_valid = 1'b0;
      n_vec++;
      if (result !== er || carryout !== eco || overflow !== eov || zero !== ez) begin
        n_fail++;
        $display("FAIL b2b cmd=%0d a=%h b=%h: res=%h co=%b ov=%b z=%b required %h/%b/%b/%b",
                 c, a, b, result, carryout, overflow, zero, er, eco, eov, ez);
      end
      prev_res = er;
    end
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    bit stray;
    cmd = 3'd0; opa = 32'hFFFF_FFFF; opb = 32'h0000_0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({in_ready, out_valid, carryout, overflow, zero} !== 5'b10000 || result !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: rdy=%b vld=%b co=%b ov=%b z=%b res=%h required 1/0/0/0/0/0",
               in_ready, out_valid, carryout, overflow, zero, result);
    end
    @(negedge clk);
    reset = 1'b0;
    prev_res = '0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stray = 1;
    end
    n_vec++;
    if (stray) begin
      n_fail++;
      $display("FAIL discarded_op: in-flight op resumed after reset (vld=%b rdy=%b) required 0/1",
               out_valid, in_ready);
    end
    do_op(3'd0, 32'd2, 32'd3, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
